instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter N, default 32: address and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0040_0000: first fetch address after reset.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 redirect_valid_i  input  1  next_pc override from the PC control stage (branch taken or jump).
REQ-007 redirect_pc_i  input  N  redirect target address.
REQ-008 imem_req_o  output  1  instruction memory read request.
REQ-009 imem_addr_o  output  N  instruction memory read address.
REQ-010 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid_i  input  1  read data valid; arrives at least 1 cycle after the grant.
REQ-012 imem_rdata_i  input  N  read data.
REQ-013 instr_valid_o  output  1  fetched instruction available to decode.
REQ-014 instr_o  output  N  fetched instruction word.
REQ-015 instr_pc_o  output  N  address of instr_o.
REQ-016 instr_ready_i  input  1  decode consumes instr_o this cycle.
REQ-017 pc_o  output  N  current fetch PC register.
REQ-018 misaligned_o  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Function
REQ-019 FSM states: FETCH, WAIT, HOLD; at most one memory request outstanding.
REQ-020 FETCH: imem_req_o=1 and imem_addr_o=pc_o; addr held stable until imem_gnt_i.
REQ-021 FETCH with imem_gnt_i: latch inflight_pc=pc_o, pc_o<=pc_o+4, go to WAIT.
REQ-022 WAIT: imem_req_o=0; on imem_rvalid_i with kill=0, register instr_o=imem_rdata_i and instr_pc_o=inflight_pc, set instr_valid_o the next cycle, go to HOLD.
REQ-023 WAIT: on imem_rvalid_i with kill=1, discard the data, clear kill, go to FETCH; instr_valid_o stays 0.
REQ-024 HOLD: instr_valid_o=1, with instr_o and instr_pc_o stable until instr_ready_i; when instr_ready_i=1, go to FETCH and deassert instr_valid_o the next cycle.
REQ-025 Redirect has priority over pc+4: redirect_valid_i=1 sets pc_o<={redirect_pc_i[N-1:2],2'b00} the next cycle, in any state.
REQ-026 Redirect in FETCH without gnt: the new address is presented the next cycle and no stale request is granted.
REQ-027 Redirect in FETCH in the same cycle as gnt: go to WAIT with kill=1.
REQ-028 Redirect in WAIT: set kill=1.
REQ-029 Redirect in the same cycle as a WAIT rvalid: discard the data, go to FETCH.
REQ-030 Redirect in HOLD: clear instr_valid_o the next cycle (flush), go to FETCH, regardless of instr_ready_i.
REQ-031 misaligned_o=1 for exactly the cycle after a redirect whose target has bits [1:0] != 0; otherwise 0.
REQ-032 PC arithmetic is modulo 2^N: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
REQ-033 imem_rvalid_i outside WAIT is ignored.
REQ-034 Decode latency: instr_valid_o rises the cycle after the accepted rvalid; minimum 3 cycles from request to valid with a 1-cycle memory.

Reset
REQ-035 On reset: pc_o=RESET_PC, state=FETCH, kill=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, misaligned_o=0.
REQ-036 imem_req_o is 0 during the reset cycle and asserts in the first cycle after reset deasserts.
REQ-037 Reset asserted mid-transaction abandons the transaction; a late rvalid after reset is ignored (state FETCH).

Verification
REQ-038 Reset release, memory with gnt and 1-cycle rvalid returning 0x00000013, ready=1 -> fetch addresses 0x00400000, 0x00400004, 0x00400008 in order, each with instr_pc_o equal to its address.
REQ-039 instr_ready_i held 0 for 5 cycles in HOLD -> instr_o and instr_pc_o stable, imem_req_o=0, no new fetch until ready.
REQ-040 Redirect to 0x00400100 while in WAIT -> the pending response is dropped, the next instr_pc_o is 0x00400100, and instr_valid_o is never set for the killed address.
REQ-041 Redirect to 0x00400102 -> misaligned_o pulses 1 cycle, and the fetch address is 0x00400100.
REQ-042 Redirect to 0xFFFFFFFC, then 2 fetches -> instr_pc_o sequence 0xFFFFFFFC, 0x00000000.
REQ-043 Reset asserted in WAIT followed by a late rvalid -> instr_valid_o stays 0, and the first request after reset uses 0x00400000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register plus a FETCH/WAIT/HOLD handshake FSM that
// keeps at most one instruction-memory read outstanding and hands words to decode.
module instr_fetch_unit #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = 'h0040_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid_i,
  input  logic [N-1:0] redirect_pc_i,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [N-1:0] imem_rdata_i,
  output logic         instr_valid_o,
  output logic [N-1:0] instr_o,
  output logic [N-1:0] instr_pc_o,
  input  logic         instr_ready_i,
  output logic [N-1:0] pc_o,
  output logic         misaligned_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] inflight_q, inflight_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] instr_pc_q, instr_pc_d;
  logic         kill_q, kill_d;
  logic         misaligned_q;
  logic [N-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc_i[N-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      kill_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      kill_q       <= kill_d;
      misaligned_q <= redirect_valid_i & (|redirect_pc_i[1:0]);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = redirect_valid_i ? redirect_tgt : pc_q;
    inflight_d = inflight_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    kill_d     = kill_q;
    case (state_q)
      S_FETCH: begin
        if (imem_gnt_i) begin
          inflight_d = pc_q;
          state_d    = S_WAIT;
          // A redirect coinciding with the grant leaves a response in flight that must be dropped.
          kill_d     = redirect_valid_i;
          if (!redirect_valid_i) pc_d = pc_q + N'(4);
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (kill_q || redirect_valid_i) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = inflight_q;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid_i) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid_i || instr_ready_i) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req_o    = (state_q == S_FETCH) && !reset;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = (state_q == S_HOLD);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign misaligned_o  = misaligned_q;

endmodule
